// File: rtl/xbar_pkg.sv
// Shared definitions for the per-slave cross bar arbitration ports.
package xbar_pkg;

    typedef enum logic [1:0] {
        ARB,
        GRANT,
        GAP
    } arb_state_t;

    // Index width for a set of n items, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xbar_order_fifo.sv
// In-order FIFO of granted master indices, used to route slave responses back.
module xbar_order_fifo
    import xbar_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [W-1:0]             i_din,
    input  logic                     i_pop,
    output logic [W-1:0]             o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = idx_w(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [CW-1:0] r_cnt;
    logic          w_push;
    logic          w_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;
    assign o_dout  = r_mem[r_rp];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= i_din;
                r_wp        <= nxt(r_wp);
            end
            if (w_pop) begin
                r_rp <= nxt(r_rp);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/xbar_slave_port_arb.sv
// Round-robin arbiter in front of one slave port; returns responses to the
// issuing master using the recorded grant order.
module xbar_slave_port_arb
    import xbar_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int AWIDTH      = 32,
    parameter int DWIDTH      = 32,
    parameter int MAX_OUTST   = 4
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [NUM_MASTERS-1:0]        m_req,
    input  logic [NUM_MASTERS*AWIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS-1:0]        m_cmd,
    input  logic [NUM_MASTERS*DWIDTH-1:0] m_wdata,
    output logic [NUM_MASTERS-1:0]        m_ack,
    output logic [NUM_MASTERS-1:0]        m_resp,
    output logic [DWIDTH-1:0]             m_rdata,
    output logic                          s_req,
    output logic [AWIDTH-1:0]             s_addr,
    output logic                          s_cmd,
    output logic [DWIDTH-1:0]             s_wdata,
    input  logic                          s_ack,
    input  logic                          s_resp,
    input  logic [DWIDTH-1:0]             s_rdata,
    output logic [$clog2(MAX_OUTST):0]    outst_cnt,
    output logic                          err_unexp_resp
);

    localparam int IW = idx_w(NUM_MASTERS);

    arb_state_t    r_state;
    logic [IW-1:0] r_grant;
    logic [IW-1:0] r_last;
    logic          r_err;
    logic [IW-1:0] w_win;
    logic [IW-1:0] w_head;
    logic          w_full;
    logic          w_empty;
    logic          w_sreq;
    logic          w_xfer;
    logic          w_pop;

    // First requester after the last grant, wrapping around.
    always_comb begin
        int  j;
        logic found;
        w_win = r_last;
        found = 1'b0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            j = (int'(r_last) + i) % NUM_MASTERS;
            if (!found && m_req[IW'(j)]) begin
                w_win = IW'(j);
                found = 1'b1;
            end
        end
    end

    assign w_sreq = (r_state == GRANT) && m_req[r_grant];
    assign w_xfer = w_sreq && s_ack;
    assign w_pop  = s_resp && !w_empty;

    always_comb begin
        s_req   = w_sreq;
        s_addr  = '0;
        s_cmd   = 1'b0;
        s_wdata = '0;
        m_ack   = '0;
        if (r_state == GRANT) begin
            s_addr         = m_addr[r_grant*AWIDTH +: AWIDTH];
            s_cmd          = m_cmd[r_grant];
            s_wdata        = m_wdata[r_grant*DWIDTH +: DWIDTH];
            m_ack[r_grant] = w_xfer;
        end
    end

    always_comb begin
        m_resp  = '0;
        m_rdata = '0;
        if (w_pop) begin
            m_resp[w_head] = 1'b1;
            m_rdata        = s_rdata;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= ARB;
            r_grant <= '0;
            r_last  <= IW'(NUM_MASTERS - 1);
        end else begin
            unique case (r_state)
                ARB: begin
                    if ((|m_req) && !w_full) begin
                        r_grant <= w_win;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_xfer) begin
                        r_last  <= r_grant;
                        r_state <= GAP;
                    end else if (!m_req[r_grant]) begin
                        r_state <= ARB;
                    end
                end
                GAP:     r_state <= ARB;
                default: r_state <= ARB;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_err <= 1'b0;
        end else if (s_resp && w_empty) begin
            r_err <= 1'b1;
        end
    end

    assign err_unexp_resp = r_err;

    xbar_order_fifo #(
        .DEPTH (MAX_OUTST),
        .W     (IW)
    ) u_order (
        .clk     (aclk),
        .rst     (areset),
        .i_push  (w_xfer),
        .i_din   (r_grant),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (outst_cnt)
    );

endmodule

// File: tb/tb_xbar_slave_port_arb.sv
// Directed and randomized checks of the per-slave arbiter against a
// transaction-level model of grant order and response routing.
module tb_xbar_slave_port_arb;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 4;

    logic            aclk = 1'b0;
    logic            areset;
    logic [N-1:0]    m_req;
    logic [N*AW-1:0] m_addr;
    logic [N-1:0]    m_cmd;
    logic [N*DW-1:0] m_wdata;
    logic [N-1:0]    m_ack;
    logic [N-1:0]    m_resp;
    logic [DW-1:0]   m_rdata;
    logic            s_req;
    logic [AW-1:0]   s_addr;
    logic            s_cmd;
    logic [DW-1:0]   s_wdata;
    logic            s_ack;
    logic            s_resp;
    logic [DW-1:0]   s_rdata;
    logic [2:0]      outst_cnt;
    logic            err_unexp_resp;

    int n_vec = 0;
    int n_err = 0;

    xbar_slave_port_arb #(
        .NUM_MASTERS (N),
        .AWIDTH      (AW),
        .DWIDTH      (DW),
        .MAX_OUTST   (MO)
    ) dut (
        .aclk           (aclk),
        .areset         (areset),
        .m_req          (m_req),
        .m_addr         (m_addr),
        .m_cmd          (m_cmd),
        .m_wdata        (m_wdata),
        .m_ack          (m_ack),
        .m_resp         (m_resp),
        .m_rdata        (m_rdata),
        .s_req          (s_req),
        .s_addr         (s_addr),
        .s_cmd          (s_cmd),
        .s_wdata        (s_wdata),
        .s_ack          (s_ack),
        .s_resp         (s_resp),
        .s_rdata        (s_rdata),
        .outst_cnt      (outst_cnt),
        .err_unexp_resp (err_unexp_resp)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_any(output logic [N-1:0] got);
        got = '0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (m_ack != '0) begin
                got = m_ack;
                return;
            end
            tick();
        end
    endtask

    task automatic do_req(input int m);
        logic [N-1:0] got;
        m_req[m] = 1'b1;
        wait_any(got);
        chk("ack_master", got, 64'(1) << m);
        tick();
        m_req[m] = 1'b0;
    endtask

    task automatic resp(input int m, input logic [DW-1:0] d);
        s_resp  = 1'b1;
        s_rdata = d;
        #1;
        chk("resp_master", m_resp, 64'(1) << m);
        chk("resp_data", m_rdata, d);
        tick();
        s_resp  = 1'b0;
        s_rdata = '0;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        tick();
        tick();
        areset = 1'b0;
    endtask

    // Transaction-level model state for the random phase
    int           q_exp[$];
    int           sq_m[$];
    logic [AW-1:0] a_v[N];
    logic [DW-1:0] w_v[N];
    logic          c_v[N];

    initial begin
        logic [N-1:0] got;
        logic [N-1:0] pend;
        logic [N-1:0] hold;
        logic [N-1:0] msk;
        int last_m;
        int done_m;
        int rounds;
        int cyc;
        int exp_m;

        areset  = 1'b1;
        m_req   = '0;
        m_addr  = '0;
        m_cmd   = '0;
        m_wdata = '0;
        s_ack   = 1'b0;
        s_resp  = 1'b0;
        s_rdata = '0;
        do_reset();

        chk("rst_sreq", s_req, 0);
        chk("rst_saddr", s_addr, 0);
        chk("rst_mack", m_ack, 0);
        chk("rst_mresp", m_resp, 0);
        chk("rst_cnt", outst_cnt, 0);
        chk("rst_err", err_unexp_resp, 0);

        // Single master with a slave that waits two cycles
        m_req[2]            = 1'b1;
        m_addr[2*AW +: AW]  = 32'h10;
        m_cmd[2]            = 1'b1;
        m_wdata[2*DW +: DW] = 32'hAA;
        tick();
        chk("single_sreq", s_req, 1);
        chk("single_addr", s_addr, 32'h10);
        chk("single_cmd", s_cmd, 1);
        chk("single_wdata", s_wdata, 32'hAA);
        chk("single_noack", m_ack, 0);
        tick();
        tick();
        s_ack = 1'b1;
        #1;
        chk("single_ack", m_ack, 4'b0100);
        tick();
        m_req[2] = 1'b0;
        s_ack    = 1'b0;
        #1;
        chk("single_cnt1", outst_cnt, 1);
        chk("single_gap", s_req, 0);
        resp(2, 32'h55);
        chk("single_cnt0", outst_cnt, 0);
        chk("idle_rdata", m_rdata, 0);

        // Response with nothing outstanding
        s_resp  = 1'b1;
        s_rdata = 32'h1234;
        #1;
        chk("unexp_noresp", m_resp, 0);
        tick();
        s_resp = 1'b0;
        chk("unexp_err", err_unexp_resp, 1);
        tick();
        tick();
        chk("unexp_sticky", err_unexp_resp, 1);
        do_reset();
        chk("unexp_clear", err_unexp_resp, 0);

        // Fill to MAX_OUTST, then a fifth request must wait for a pop
        s_ack = 1'b1;
        for (int i = 0; i < MO; i++) do_req(1);
        chk("full_cnt", outst_cnt, MO);
        m_req[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("full_block", s_req, 0);
        end
        s_resp  = 1'b1;
        s_rdata = 32'hF0;
        #1;
        chk("full_pop_m", m_resp, 4'b0010);
        tick();
        s_resp = 1'b0;
        #1;
        chk("full_cnt3", outst_cnt, 3);
        chk("full_still0", s_req, 0);
        tick();
        chk("full_rise", s_req, 1);
        chk("full_ack0", m_ack, 4'b0001);
        tick();
        m_req[0] = 1'b0;
        chk("full_cnt4", outst_cnt, 4);
        resp(1, 32'h101);
        resp(1, 32'h102);
        resp(1, 32'h103);
        resp(0, 32'h104);
        chk("drain_cnt", outst_cnt, 0);

        // Accept and respond in the same cycle at two outstanding
        do_req(3);
        do_req(0);
        m_req[1] = 1'b1;
        wait_any(got);
        s_resp  = 1'b1;
        s_rdata = 32'h77;
        #1;
        chk("both_ack", got, 4'b0010);
        chk("both_resp", m_resp, 4'b1000);
        chk("both_rdata", m_rdata, 32'h77);
        tick();
        s_resp   = 1'b0;
        m_req[1] = 1'b0;
        #1;
        chk("both_cnt", outst_cnt, 2);
        resp(0, 32'h88);
        resp(1, 32'h99);

        // Reset while granting with three outstanding
        do_req(0);
        do_req(1);
        do_req(2);
        s_ack    = 1'b0;
        m_req[3] = 1'b1;
        for (int i = 0; i < 10 && !s_req; i++) tick();
        chk("mid_grant", s_req, 1);
        chk("mid_cnt3", outst_cnt, 3);
        areset = 1'b1;
        tick();
        chk("mid_sreq", s_req, 0);
        chk("mid_saddr", s_addr, 0);
        chk("mid_swdata", s_wdata, 0);
        chk("mid_mack", m_ack, 0);
        chk("mid_cnt", outst_cnt, 0);
        areset   = 1'b0;
        m_req[3] = 1'b0;
        s_resp   = 1'b1;
        #1;
        chk("mid_noresp", m_resp, 0);
        tick();
        s_resp = 1'b0;
        chk("mid_err", err_unexp_resp, 1);
        s_ack    = 1'b1;
        m_req[1] = 1'b1;
        m_req[3] = 1'b1;
        wait_any(got);
        chk("mid_rr_first", got, 4'b0010);
        tick();
        m_req[1] = 1'b0;
        wait_any(got);
        chk("mid_rr_second", got, 4'b1000);
        tick();
        m_req[3] = 1'b0;
        do_reset();
        s_ack = 1'b0;

        // Randomized rounds: grant order is cyclic from the last winner
        last_m = N - 1;
        pend   = '0;
        hold   = '0;
        done_m = -1;
        rounds = 0;
        cyc    = 0;
        while ((rounds < 60 || pend != 0 || hold != 0 || done_m >= 0)
               && cyc < 20000) begin
            cyc++;
            for (int m = 0; m < N; m++) begin
                if (hold[m]) begin
                    hold[m]  = 1'b0;
                    m_req[m] = 1'b0;
                end
            end
            if (done_m >= 0) begin
                if ($urandom_range(0, 1) == 1) hold[done_m] = 1'b1;
                else m_req[done_m] = 1'b0;
                done_m = -1;
            end
            if (pend == 0 && hold == 0 && rounds < 60) begin
                rounds++;
                msk = N'($urandom_range(1, (1 << N) - 1));
                for (int m = 0; m < N; m++) begin
                    if (msk[m]) begin
                        a_v[m] = $urandom;
                        w_v[m] = $urandom;
                        c_v[m] = 1'($urandom_range(0, 1));
                        m_addr[m*AW +: AW]  = a_v[m];
                        m_wdata[m*DW +: DW] = w_v[m];
                        m_cmd[m]            = c_v[m];
                        m_req[m]            = 1'b1;
                    end
                end
                pend = msk;
                for (int k = 1; k <= N; k++) begin
                    if (msk[(last_m + k) % N]) q_exp.push_back((last_m + k) % N);
                end
            end
            s_ack   = ($urandom_range(0, 3) != 0);
            s_resp  = (sq_m.size() > 0) && ($urandom_range(0, 2) == 0);
            s_rdata = $urandom;
            #4;
            chk("rnd_cnt", outst_cnt, sq_m.size());
            if (sq_m.size() == MO) chk("rnd_full", s_req, 0);
            if (s_resp) begin
                chk("rnd_resp", m_resp, 64'(1) << sq_m[0]);
                chk("rnd_rdata", m_rdata, s_rdata);
                void'(sq_m.pop_front());
            end else begin
                chk("rnd_noresp", m_resp, 0);
                chk("rnd_zdata", m_rdata, 0);
            end
            if (s_req && s_ack) begin
                exp_m = (q_exp.size() > 0) ? q_exp[0] : -1;
                chk("rnd_ack", m_ack, (exp_m >= 0) ? (64'(1) << exp_m) : 64'(0));
                if (exp_m >= 0) begin
                    chk("rnd_addr", s_addr, a_v[exp_m]);
                    chk("rnd_wdata", s_wdata, w_v[exp_m]);
                    chk("rnd_cmd", s_cmd, c_v[exp_m]);
                    void'(q_exp.pop_front());
                    pend[exp_m] = 1'b0;
                    sq_m.push_back(exp_m);
                    last_m = exp_m;
                    done_m = exp_m;
                end
            end else begin
                chk("rnd_noack", m_ack, 0);
            end
            tick();
        end
        chk("rnd_pending", {pend, hold}, 0);
        chk("rnd_queue", q_exp.size(), 0);
        s_ack = 1'b0;
        while (sq_m.size() > 0) begin
            resp(sq_m[0], $urandom);
            void'(sq_m.pop_front());
        end
        chk("rnd_drained", outst_cnt, 0);
        chk("rnd_noerr", err_unexp_resp, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
